// File: rtl/clock_monitor_pkg.sv
// Shared state encoding and default parameter values for clock_monitor.
package clock_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_LOST    = 2'd3
   } mon_state_t;

   localparam int DEF_CNT_W      = 16;
   localparam int DEF_EXP_PERIOD = 4;
   localparam int DEF_TOL        = 0;
   localparam int DEF_LOCK_COUNT = 4;
   localparam int DEF_TIMEOUT    = 64;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// sync_level is delayed one stage so it lines up with the rise pulse.
module sync_edge_detect
   import clock_monitor_pkg::*;
(
   input  logic clk_in,
   input  logic reset,
   input  logic async_in,
   output logic sync_level,
   output logic rise
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic rise_q;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
      end
   end

   assign sync_level = prev_q;
   assign rise       = rise_q;

endmodule

// File: rtl/clock_monitor.sv
// Measures the period of clk_mon in clk_in cycles and tracks lock / loss.
// Define CLOCK_MONITOR_DUTY_EN to add the high_time (duty) measurement output.
module clock_monitor
   import clock_monitor_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int EXP_PERIOD = DEF_EXP_PERIOD,
   parameter int TOL        = DEF_TOL,
   parameter int LOCK_COUNT = DEF_LOCK_COUNT,
   parameter int TIMEOUT    = DEF_TIMEOUT
)
(
   input  logic             clk_in,
   input  logic             reset,
   input  logic             clk_mon,
   output logic             mon_rise,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic             lost
`ifdef CLOCK_MONITOR_DUTY_EN
   ,
   output logic [CNT_W-1:0] high_time
`endif
);

   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] EXP_P     = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W-1:0] TOL_P     = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] TIMEOUT_P = CNT_W'(TIMEOUT);

   if (LOCK_COUNT < 1) begin : g_chk_lock
      $error("clock_monitor: LOCK_COUNT must be >= 1");
   end
   if (TIMEOUT < 0 || longint'(TIMEOUT) >= (longint'(1) << CNT_W) - longint'(1)) begin : g_chk_timeout
      $error("clock_monitor: TIMEOUT must be below 2**CNT_W-1");
   end

   logic               rise;
   logic               mon_level;
   mon_state_t         state_q, state_n;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   period_q;
   logic [CNT_W-1:0]   p_meas;
   logic [CNT_W-1:0]   diff;
   logic               in_tol;
   logic               meas_valid;
   logic               timeout;
   logic [MATCH_W-1:0] match_q, match_n;
   logic               lock_hit;
   logic               pv_q;
   logic               locked_q;
   logic               lost_q;

   sync_edge_detect u_sync (
      .clk_in     (clk_in),
      .reset      (reset),
      .async_in   (clk_mon),
      .sync_level (mon_level),
      .rise       (rise)
   );

   assign p_meas     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
   assign diff       = (p_meas >= EXP_P) ? p_meas - EXP_P : EXP_P - p_meas;
   assign in_tol     = (diff <= TOL_P);
   // The first rise after IDLE or LOST has no reference edge, so only
   // rises seen while already measuring produce a period.
   assign meas_valid = rise && (state_q == ST_MEASURE || state_q == ST_LOCKED);
   assign timeout    = (cnt_q == TIMEOUT_P);
   assign lock_hit   = (32'(match_q) + 32'd1) == 32'(LOCK_COUNT);

   always_comb begin
      state_n = state_q;
      match_n = match_q;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_n = ST_MEASURE;
               match_n = '0;
            end else if (timeout) begin
               state_n = ST_LOST;
            end
         end
         ST_MEASURE: begin
            if (meas_valid) begin
               if (!in_tol) begin
                  match_n = '0;
               end else if (lock_hit) begin
                  state_n = ST_LOCKED;
                  match_n = '0;
               end else begin
                  match_n = match_q + MATCH_W'(1);
               end
            end else if (timeout) begin
               state_n = ST_LOST;
            end
         end
         ST_LOCKED: begin
            if (meas_valid) begin
               if (!in_tol) begin
                  state_n = ST_MEASURE;
                  match_n = '0;
               end
            end else if (timeout) begin
               state_n = ST_LOST;
            end
         end
         ST_LOST: begin
            if (rise) begin
               state_n = ST_MEASURE;
               match_n = '0;
            end
         end
         default: begin
            state_n = ST_IDLE;
            match_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         match_q  <= '0;
         cnt_q    <= '0;
         period_q <= '0;
         pv_q     <= 1'b0;
         locked_q <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         state_q  <= state_n;
         match_q  <= match_n;
         cnt_q    <= rise ? '0 : ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1));
         if (meas_valid) begin
            period_q <= p_meas;
         end
         pv_q     <= meas_valid;
         locked_q <= (state_n == ST_LOCKED);
         lost_q   <= (state_n == ST_LOST);
      end
   end

   assign mon_rise     = rise;
   assign period       = period_q;
   assign period_valid = pv_q;
   assign locked       = locked_q;
   assign lost         = lost_q;

`ifdef CLOCK_MONITOR_DUTY_EN
   logic [CNT_W-1:0] hcnt_q;
   logic [CNT_W-1:0] h_meas;
   logic [CNT_W-1:0] high_q;

   // The rise cycle itself closes the window, so it is counted before clearing.
   assign h_meas = (mon_level && hcnt_q != CNT_MAX) ? hcnt_q + CNT_W'(1) : hcnt_q;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         hcnt_q <= '0;
         high_q <= '0;
      end else begin
         hcnt_q <= rise ? '0 : h_meas;
         if (meas_valid) begin
            high_q <= h_meas;
         end
      end
   end

   assign high_time = high_q;
`else
   logic unused_level;
   assign unused_level = mon_level;
`endif

endmodule
